// File: rtl/sramlike_mem_responder.sv
// SRAM-like data-bus slave backed by a word RAM with a fixed response latency.
// Optional SRAMLIKE_ADDR_STALL_EN: an LFSR inserts pseudo-random addr_ok stalls in IDLE.
module sramlike_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam logic [3:0] LatM1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  data_ok_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_q [2**ADDR_WIDTH];

    logic                  accept_en;
    logic [ADDR_WIDTH-1:0] word_idx, next_idx;
    logic [3:0]            lane_mask;
    logic [31:0]           bit_mask;
    logic                  unused_addr;

    // Upper address bits alias onto the RAM.
    assign unused_addr = ^data_addr[31:ADDR_WIDTH+2];

`ifdef SRAMLIKE_ADDR_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign accept_en = ~lfsr_q[0];
`else
    assign accept_en = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_addr_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                data_addr_ok = data_req & accept_en & rst;
                if (data_addr_ok) begin
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr[ADDR_WIDTH+1:0];
                    wdata_d = data_wdata;
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatM1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign next_idx = addr_d[ADDR_WIDTH+1:2];

    always_comb begin
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign bit_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_ok_q <= (state_d == StResp);
            // Next-state fields so a zero-latency read sees the request being accepted.
            if (state_d == StResp) begin
                rdata_q <= wr_d ? 32'd0 : mem_q[next_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StResp && wr_q) begin
            mem_q[word_idx] <= (mem_q[word_idx] & ~bit_mask) | (wdata_q & bit_mask);
        end
    end

    assign data_rdata   = rdata_q;
    assign data_data_ok = data_ok_q;

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Scoreboard bench: three responders (latency 0, 2, 5) driven by directed and random traffic.
module tb_sramlike_mem_responder;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_fin = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 2 : 5;

        logic        rst_n, req, wr, aok, dok;
        logic [1:0]  sz;
        logic [31:0] addr, wdata, rdata;
        exp_t        q[$];
        int          issued = 0;
        int          done = 0;
        bit [31:0]   model [int unsigned];

        sramlike_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
            .clk         (clk),
            .rst         (rst_n),
            .data_req    (req),
            .data_wr     (wr),
            .data_size   (sz),
            .data_addr   (addr),
            .data_wdata  (wdata),
            .data_rdata  (rdata),
            .data_addr_ok(aok),
            .data_data_ok(dok)
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d %s", LAT, s);
        endfunction

        // Reference: RAM of 1024 words indexed by byte address / 4, higher bits alias.
        function automatic logic [31:0] model_op(input bit w, input bit [1:0] s,
                                                 input bit [31:0] a, input bit [31:0] d);
            int unsigned ix = (a / 4) % 1024;
            int          lo, n;
            bit [31:0]   word;
            word = model.exists(ix) ? model[ix] : 32'h0;
            if (!w) return word;
            if (s == 0) begin
                lo = int'(a % 4); n = 1;
            end else if (s == 1) begin
                lo = (a % 4 >= 2) ? 2 : 0; n = 2;
            end else begin
                lo = 0; n = 4;
            end
            for (int b = lo; b < lo + n; b++) word[8*b +: 8] = d[8*b +: 8];
            model[ix] = word;
            return 32'h0;
        endfunction

        task automatic drain();
            int w = 0;
            while (done < issued && w < 200) begin
                @(posedge clk);
                w++;
            end
            if (done < issued) chk(nm("drain timeout"), 32'(done), 32'(issued));
        endtask

        task automatic do_op(input bit w, input bit [1:0] s, input bit [31:0] a,
                             input bit [31:0] d, input bit hold, input bit must_now);
            int   t = 0;
            exp_t e;
            drain();
            @(negedge clk);
            req = 1'b1; wr = w; sz = s; addr = a; wdata = d;
            #1;
`ifndef SRAMLIKE_ADDR_STALL_EN
            if (must_now) chk(nm("accept after reset"), {31'd0, aok}, 32'd1);
`endif
            while (aok !== 1'b1 && t < 64) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk(nm("addr_ok accept"), {31'd0, aok}, 32'd1);
            if (aok !== 1'b1) begin
                req = 1'b0;
                return;
            end
            e.data = model_op(w, s, a, d);
            e.cyc  = cyc + 1 + int'(LAT);
            q.push_back(e);
            issued++;
            @(negedge clk);
            if (hold) begin
                t = 0;
                forever begin
                    #1;
                    if (done >= issued || t > 40) break;
                    chk(nm("addr_ok busy"), {31'd0, aok}, 32'd0);
                    @(negedge clk);
                    t++;
                end
            end
            req = 1'b0;
        endtask

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && dok === 1'b1) begin
                    if (q.size() == 0) begin
                        chk(nm("unexpected data_ok"), {31'd0, dok}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk(nm("rdata"), rdata, e.data);
                        chk(nm("data_ok cycle"), 32'(cyc), 32'(e.cyc));
                    end
                    done++;
                end
            end
        end

        initial begin
            int t;
            rst_n = 1'b0; req = 1'b1; wr = 1'b0; sz = 2'b00; addr = 32'd0; wdata = 32'd0;
            repeat (2) @(negedge clk);
            #1;
            chk(nm("reset addr_ok"), {31'd0, aok}, 32'd0);
            chk(nm("reset data_ok"), {31'd0, dok}, 32'd0);
            chk(nm("reset rdata"), rdata, 32'd0);
            req = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;

            do_op(1, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 0, 0);
            do_op(0, 2'b10, 32'h0000_0010, 32'h0, 0, 0);
            do_op(1, 2'b10, 32'h0000_0020, 32'h11223344, 0, 0);
            do_op(1, 2'b00, 32'h0000_0022, 32'h00AA0000, 0, 0);
            do_op(0, 2'b10, 32'h0000_0020, 32'h0, 1, 0);
            do_op(1, 2'b10, 32'h0000_0020, 32'h11223344, 0, 0);
            do_op(1, 2'b01, 32'h0000_0022, 32'hBEEF0000, 1, 0);
            do_op(0, 2'b10, 32'h0000_0020, 32'h0, 0, 0);
            do_op(1, 2'b10, 32'h0000_0100, 32'hCAFEF00D, 0, 0);
            do_op(0, 2'b10, 32'h0000_1100, 32'h0, 0, 0);

            for (int i = 0; i < 16; i++)
                do_op(1, 2'b10, ($urandom & 32'hFFFF_F000) | 32'(i * 4), $urandom, 0, 0);
            for (int i = 0; i < 40; i++)
                do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                      $urandom, 1'($urandom_range(0, 1)), 0);

            if (LAT > 0) begin
                do_op(1, 2'b10, 32'h0000_0040, 32'h12345678, 0, 0);
                drain();
                @(negedge clk);
                req = 1'b1; wr = 1'b1; sz = 2'b10; addr = 32'h40; wdata = 32'h55555555;
                t = 0;
                #1;
                while (aok !== 1'b1 && t < 64) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                chk(nm("abort addr_ok"), {31'd0, aok}, 32'd1);
                @(negedge clk);
                req = 1'b0;
                rst_n = 1'b0;
                #1;
                chk(nm("abort data_ok"), {31'd0, dok}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                do_op(0, 2'b10, 32'h0000_0040, 32'h0, 0, 1);
            end

            drain();
            repeat (8) @(negedge clk);
            chk(nm("queue empty"), 32'(q.size()), 32'd0);
            n_fin++;
        end
    end

    initial begin
        int w = 0;
        while (n_fin < 3 && w < 20000) begin
            @(posedge clk);
            w++;
        end
        if (n_fin < 3) chk("global timeout", 32'(n_fin), 32'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
